// File: rtl/shm_i2c_arbiter_if.sv
// Bundle of the requester-side handshake and the I2C-controller-side bus
// seen by the shared-I2C arbiter. The arbiter takes the slave view and the
// requesters/controller (or a bench) take the master view.
interface shm_i2c_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int REPEAT_SZ = 6
);
  // Requester side
  logic [NUM_REQ-1:0]           req_valid;
  logic [8*NUM_REQ-1:0]         req_location;
  logic [8*NUM_REQ-1:0]         req_data;
  logic [REPEAT_SZ*NUM_REQ-1:0] req_repeat;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           done;
  logic                         done_ok;
  logic                         arb_busy;
  logic [7:0]                   error_count;

  // Controller side
  logic                         i2c_activate;
  logic [7:0]                   i2c_location;
  logic [7:0]                   i2c_data;
  logic [REPEAT_SZ-1:0]         i2c_repeat;
  logic                         i2c_busy;
  logic                         i2c_success;
  logic                         i2c_abort;

  modport slave (
    input  req_valid, req_location, req_data, req_repeat,
    input  i2c_busy, i2c_success, i2c_abort,
    output req_ready, done, done_ok, arb_busy, error_count,
    output i2c_activate, i2c_location, i2c_data, i2c_repeat
  );

  modport master (
    output req_valid, req_location, req_data, req_repeat,
    output i2c_busy, i2c_success, i2c_abort,
    input  req_ready, done, done_ok, arb_busy, error_count,
    input  i2c_activate, i2c_location, i2c_data, i2c_repeat
  );
endinterface

// File: rtl/shm_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C write controller between NUM_REQ
// requesters. One transaction at a time: grant, wait for the controller to
// go busy (with a start timeout), wait for it to go idle, then report the
// outcome to the owner with a one-cycle done pulse.
module shm_i2c_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int REPEAT_SZ     = 6,
  parameter int START_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset_n,
  shm_i2c_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(START_TIMEOUT + 1);
  localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [TMR_W-1:0]     timer_reg;
  logic                 success_seen_reg;
  logic                 abort_seen_reg;
  logic [NUM_REQ-1:0]   req_ready_reg;
  logic [NUM_REQ-1:0]   done_reg;
  logic                 done_ok_reg;
  logic                 arb_busy_reg;
  logic                 activate_reg;
  logic [7:0]           location_reg;
  logic [7:0]           data_reg;
  logic [REPEAT_SZ-1:0] repeat_reg;
  logic [7:0]           error_count_reg;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic [7:0]           win_location;
  logic [7:0]           win_data;
  logic [REPEAT_SZ-1:0] win_repeat;
  logic                 finish_ok;
  logic [7:0]           error_count_inc;

  // Round-robin search: scan offsets from the pointer downwards so that the
  // smallest offset with a valid request is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (bus.req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_location = bus.req_location[8*win_idx +: 8];
  assign win_data     = bus.req_data[8*win_idx +: 8];
  assign win_repeat   = bus.req_repeat[REPEAT_SZ*win_idx +: REPEAT_SZ];

  // Status pulses arriving in the same cycle busy falls still count.
  assign finish_ok = (success_seen_reg | bus.i2c_success) &
                     ~(abort_seen_reg | bus.i2c_abort);

  assign error_count_inc = (error_count_reg == 8'hFF) ? 8'hFF : error_count_reg + 8'd1;

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      owner_reg        <= '0;
      timer_reg        <= '0;
      success_seen_reg <= 1'b0;
      abort_seen_reg   <= 1'b0;
      req_ready_reg    <= '0;
      done_reg         <= '0;
      done_ok_reg      <= 1'b0;
      arb_busy_reg     <= 1'b0;
      activate_reg     <= 1'b0;
      location_reg     <= '0;
      data_reg         <= '0;
      repeat_reg       <= '0;
      error_count_reg  <= '0;
    end else begin
      req_ready_reg <= '0;
      done_reg      <= '0;
      case (state_reg)
        IDLE: begin
          done_ok_reg  <= 1'b0;
          arb_busy_reg <= 1'b0;
          if (win_found && !bus.i2c_busy) begin
            state_reg              <= WAIT_BUSY;
            owner_reg              <= win_idx;
            ptr_reg                <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            req_ready_reg[win_idx] <= 1'b1;
            arb_busy_reg           <= 1'b1;
            activate_reg           <= 1'b1;
            location_reg           <= win_location;
            data_reg               <= win_data;
            repeat_reg             <= win_repeat;
            timer_reg              <= '0;
            success_seen_reg       <= 1'b0;
            abort_seen_reg         <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          if (bus.i2c_success) success_seen_reg <= 1'b1;
          if (bus.i2c_abort)   abort_seen_reg   <= 1'b1;
          if (bus.i2c_busy) begin
            activate_reg <= 1'b0;
            state_reg    <= WAIT_DONE;
          end else if (timer_reg == TMR_LAST) begin
            // Controller never started: report failure to the owner.
            activate_reg        <= 1'b0;
            state_reg           <= COMPLETE;
            done_reg[owner_reg] <= 1'b1;
            done_ok_reg         <= 1'b0;
            error_count_reg     <= error_count_inc;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.i2c_success) success_seen_reg <= 1'b1;
          if (bus.i2c_abort)   abort_seen_reg   <= 1'b1;
          if (!bus.i2c_busy) begin
            state_reg           <= COMPLETE;
            done_reg[owner_reg] <= 1'b1;
            done_ok_reg         <= finish_ok;
            if (!finish_ok) begin
              error_count_reg <= error_count_inc;
            end
          end
        end
        COMPLETE: begin
          state_reg    <= IDLE;
          done_ok_reg  <= 1'b0;
          arb_busy_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_reg;
  assign bus.done         = done_reg;
  assign bus.done_ok      = done_ok_reg;
  assign bus.arb_busy     = arb_busy_reg;
  assign bus.error_count  = error_count_reg;
  assign bus.i2c_activate = activate_reg;
  assign bus.i2c_location = location_reg;
  assign bus.i2c_data     = data_reg;
  assign bus.i2c_repeat   = repeat_reg;

endmodule

// File: doc/shm_i2c_arbiter.md
SHM_I2C_ARBITER -- requirements
Module: shm_i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing the I2C controller (2..8).
REQ-002 Parameter REPEAT_SZ, default 6, width of the data-repeat field.
REQ-003 Parameter START_TIMEOUT, default 1024, clk cycles to wait for i2c_busy to rise after activate.
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port req_valid  input  NUM_REQ  requester i has a write pending.
REQ-007 Port req_location  input  8*NUM_REQ  register address, requester i at bits [8i+7:8i].
REQ-008 Port req_data  input  8*NUM_REQ  data byte, same packing.
REQ-009 Port req_repeat  input  REPEAT_SZ*NUM_REQ  repeat count, same packing.
REQ-010 Port req_ready  output  NUM_REQ  one-cycle grant/accept pulse.
REQ-011 Port done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-012 Port done_ok  output  1  valid with any done bit: 1 = success, 0 = abort/timeout/no status.
REQ-013 Port arb_busy  output  1  high from grant until the done pulse, inclusive.
REQ-014 Port i2c_activate, i2c_location, i2c_data, i2c_repeat  output  1/8/8/REPEAT_SZ  drive the I2C controller.
REQ-015 Port i2c_busy, i2c_success, i2c_abort  input  1 each  status from the I2C controller.
REQ-016 Port error_count  output  8  saturating count of failed transactions.

Function
REQ-017 States: IDLE, WAIT_BUSY, WAIT_DONE, COMPLETE; all outputs registered.
REQ-018 IDLE: when any req_valid=1 and i2c_busy=0, grant winner w; next cycle req_ready[w]=1, i2c_* fields = requester w's fields sampled at decision, i2c_activate=1, state WAIT_BUSY.
REQ-019 Arbitration round-robin: search starts at pointer p (reset 0); after grant to w, p = (w+1) mod NUM_REQ.
REQ-020 Requester SHALL hold req_valid and fields stable until it sees req_ready; deasserting req_valid before grant withdraws the request with no side effect.
REQ-021 req_valid is ignored in all states except IDLE; no second grant while arb_busy=1.
REQ-022 WAIT_BUSY: on i2c_busy=1, i2c_activate=0, state WAIT_DONE; timeout counter counts cycles in WAIT_BUSY.
REQ-023 WAIT_BUSY timeout: when counter reaches START_TIMEOUT, i2c_activate=0, state COMPLETE with failure.
REQ-024 success_seen/abort_seen flags clear at grant, set on i2c_success/i2c_abort in any cycle of WAIT_BUSY or WAIT_DONE, including the cycle i2c_busy falls.
REQ-025 WAIT_DONE: on i2c_busy=0, state COMPLETE.
REQ-026 COMPLETE (one cycle): done[w]=1, done_ok = success_seen & ~abort_seen & ~timeout; next state IDLE.
REQ-027 done_ok=0 increments error_count, saturating at 255.
REQ-028 Earliest next grant pulse is 2 cycles after done pulse (IDLE decision, then registered grant).
REQ-029 i2c_location/data/repeat hold their values until the next grant.

Reset
REQ-030 reset_n=0 asynchronously forces state IDLE, p=0, req_ready=0, done=0, done_ok=0, arb_busy=0, i2c_activate=0, i2c_location=0, i2c_data=0, i2c_repeat=0, error_count=0, flags and timeout counter cleared.
REQ-031 Reset mid-transaction abandons it with no done pulse; controller-side activity is not tracked after reset.

Verification
REQ-032 Single request: req_valid[1]=1, loc 0xFD, data 0x0B, repeat 0; model busy 3 cycles after activate for 20 cycles with success pulse -> req_ready[1] pulse, i2c fields 0xFD/0x0B/0, done[1] with done_ok=1, error_count=0.
REQ-033 All three valid simultaneously, continuously re-requesting -> grant order 0,1,2,0,1,2; never two grants overlap.
REQ-034 Abort pulse during busy (no success) -> done_ok=0, error_count increments 0->1.
REQ-035 Controller never raises busy -> i2c_activate drops and done pulses with done_ok=0 exactly START_TIMEOUT cycles into WAIT_BUSY.
REQ-036 reset_n low during WAIT_DONE -> all outputs 0 same cycle, no done pulse; after release, pending req_valid[2] granted first-search from 0 ordering.
REQ-037 Force 256 failures -> error_count stays 255.
